// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch constants and the fetch controller state encoding.
package fetch_ctrl_pkg;

   localparam logic [31:0] IMEM_BASE_ADDR = 32'h0100_0000;
   localparam logic [31:0] INSN_NOP       = 32'h0000_0013;
   localparam int unsigned PC_STEP        = 4;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_REQ,
      FS_WAIT,
      FS_DROP
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and imem.
interface fetch_ctrl_if #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned AWIDTH = 32
);
   logic              imem_req_o;
   logic [AWIDTH-1:0] imem_addr_o;
   logic [DWIDTH-1:0] imem_rdata_i;
   logic              imem_rvalid_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_rdata_i,
      input  imem_rvalid_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_rdata_i,
      output imem_rvalid_i
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: owns the PC, buffers one
// returned word for decode, and handles stall back-pressure and redirects.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned       DWIDTH   = 32,
   parameter int unsigned       AWIDTH   = 32,
   parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(IMEM_BASE_ADDR)
) (
   input  logic              clk,
   input  logic              rst,
   fetch_ctrl_if.master      imem,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [AWIDTH-1:0] redirect_pc_i,
   output logic [AWIDTH-1:0] pc_o,
   output logic [DWIDTH-1:0] insn_o,
   output logic              insn_valid_o,
   output logic [31:0]       fetch_count_o
);

   fetch_state_e      state_q;
   fetch_state_e      state_d;
   logic [AWIDTH-1:0] pc_q;
   logic              accept_c;
   logic              req_c;
   logic              load_c;

   assign imem.imem_req_o  = req_c;
   assign imem.imem_addr_o = pc_q;

   // Next state and request/load decode.
   always_comb begin
      state_d  = state_q;
      req_c    = 1'b0;
      load_c   = 1'b0;
      accept_c = insn_valid_o && !stall_i;
      case (state_q)
         FS_IDLE: state_d = FS_REQ;
         FS_REQ: begin
            req_c = !insn_valid_o || accept_c;
            if (req_c) begin
               state_d = redirect_i ? FS_DROP : FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (imem.imem_rvalid_i) begin
               load_c  = !redirect_i;
               state_d = FS_REQ;
            end else if (redirect_i) begin
               state_d = FS_DROP;
            end
         end
         FS_DROP: begin
            // A redirect here only retargets pc_q; the stale response still has to drain.
            if (imem.imem_rvalid_i) begin
               state_d = FS_REQ;
            end
         end
         default: state_d = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // PC, output buffer and accept counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         pc_o          <= RESET_PC;
         insn_o        <= DWIDTH'(INSN_NOP);
         insn_valid_o  <= 1'b0;
         fetch_count_o <= 32'd0;
      end else begin
         if (redirect_i) begin
            pc_q         <= redirect_pc_i & ~AWIDTH'(PC_STEP - 1);
            insn_valid_o <= 1'b0;
            insn_o       <= DWIDTH'(INSN_NOP);
         end else if (load_c) begin
            insn_o       <= imem.imem_rdata_i;
            pc_o         <= pc_q;
            insn_valid_o <= 1'b1;
            pc_q         <= pc_q + AWIDTH'(PC_STEP);
         end else if (accept_c) begin
            insn_valid_o <= 1'b0;
         end
         if (accept_c && !redirect_i) begin
            fetch_count_o <= fetch_count_o + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written
// redirect/reset corner sequences, and randomized traffic against a reference model.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   localparam logic [31:0] BASE = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] pc_o;
   logic [31:0] insn_o;
   logic        insn_valid_o;
   logic [31:0] fetch_count_o;

   fetch_ctrl_if #(.DWIDTH(32), .AWIDTH(32)) imem_bus ();

   fetch_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (imem_bus),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .pc_o          (pc_o),
      .insn_o        (insn_o),
      .insn_valid_o  (insn_valid_o),
      .fetch_count_o (fetch_count_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: transaction-level view (outstanding request + discard flag).
   logic [31:0] m_pc, m_pco, m_insn, m_cnt;
   logic        m_valid, m_started, m_outst, m_disc;

   // Memory model: one pending response delivered lat cycles after the request.
   logic        mem_pend;
   int          mem_due;
   logic [31:0] mem_data;
   int          cyc;
   int          lat;

   logic        cur_st, cur_rd, cur_r, cur_rv;
   logic [31:0] cur_rpc, cur_rdata;

   typedef struct {
      logic        st;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evalid;
      logic [31:0] epc;
      logic [31:0] einsn;
      logic [31:0] ecnt;
   } vec_t;

   vec_t tbl[11];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == BASE) return 32'h0000_0013;
      if (a == BASE + 32'd4) return 32'h0010_0093;
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pc      = BASE;
      m_pco     = BASE;
      m_insn    = INSN_NOP;
      m_cnt     = 32'd0;
      m_valid   = 1'b0;
      m_started = 1'b0;
      m_outst   = 1'b0;
      m_disc    = 1'b0;
   endtask

   // Apply this cycle's inputs and memory response, then let outputs settle.
   task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic r);
      cur_st  = st;
      cur_rd  = rd;
      cur_rpc = rpc;
      cur_r   = r;
      cur_rv  = mem_pend && (cyc == mem_due);
      cur_rdata = cur_rv ? mem_data : 32'hDEAD_BEEF;
      stall_i       = st;
      redirect_i    = rd;
      redirect_pc_i = rpc;
      rst           = r;
      imem_bus.imem_rvalid_i = cur_rv;
      imem_bus.imem_rdata_i  = cur_rdata;
      #1;
   endtask

   // Compare against the model, advance model and memory, cross the clock edge.
   task automatic finish();
      logic m_req, acc, resp, load;
      acc   = m_valid && !cur_st;
      m_req = m_started && !m_outst && (!m_valid || !cur_st);
      resp  = m_outst && cur_rv;
      load  = resp && !m_disc && !cur_rd;

      chk("model imem_req_o", 32'(imem_bus.imem_req_o), 32'(m_req));
      if (m_req) chk("model imem_addr_o", imem_bus.imem_addr_o, m_pc);
      chk("model insn_valid_o", 32'(insn_valid_o), 32'(m_valid));
      chk("model pc_o", pc_o, m_pco);
      chk("model insn_o", insn_o, m_insn);
      chk("model fetch_count_o", fetch_count_o, m_cnt);

      if (cur_rv) mem_pend = 1'b0;
      if (imem_bus.imem_req_o && !cur_r) begin
         mem_pend = 1'b1;
         mem_due  = cyc + lat;
         mem_data = mem_word(imem_bus.imem_addr_o);
      end

      if (cur_r) begin
         model_reset();
      end else begin
         if (cur_rd) begin
            m_pc    = cur_rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_insn  = INSN_NOP;
         end else if (load) begin
            m_insn  = cur_rdata;
            m_pco   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
         end else if (acc) begin
            m_valid = 1'b0;
         end
         if (acc && !cur_rd) m_cnt = m_cnt + 32'd1;
         if (m_req) begin
            m_outst = 1'b1;
            m_disc  = cur_rd;
         end else if (resp) begin
            m_outst = 1'b0;
            m_disc  = 1'b0;
         end else if (m_outst && cur_rd) begin
            m_disc = 1'b1;
         end
         m_started = 1'b1;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
      drive(st, rd, rpc, 1'b0);
      finish();
   endtask

   task automatic reset_dut();
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      finish();
      mem_pend = 1'b0;
   endtask

   // Run until insn_valid_o rises (bounded) and check the delivered word.
   task automatic expect_word(input string name, input logic [31:0] pc);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 12; k++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b0);
         if (insn_valid_o) begin
            found = 1'b1;
            chk({name, " pc_o"}, pc_o, pc);
            chk({name, " insn_o"}, insn_o, mem_word(pc));
         end
         finish();
         if (found) break;
      end
      chk({name, " valid seen"}, 32'(found), 32'd1);
   endtask

   initial begin
      // Reset release, 1-cycle memory, then 5-cycle stall with a word held.
      tbl[0]  = '{1'b0, 1'b0, 32'h0,          1'b0, BASE, 32'h13,        32'd0};
      tbl[1]  = '{1'b0, 1'b1, BASE,           1'b0, BASE, 32'h13,        32'd0};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,          1'b0, BASE, 32'h13,        32'd0};
      tbl[3]  = '{1'b1, 1'b0, 32'h0,          1'b1, BASE, 32'h13,        32'd0};
      tbl[4]  = '{1'b1, 1'b0, 32'h0,          1'b1, BASE, 32'h13,        32'd0};
      tbl[5]  = '{1'b1, 1'b0, 32'h0,          1'b1, BASE, 32'h13,        32'd0};
      tbl[6]  = '{1'b1, 1'b0, 32'h0,          1'b1, BASE, 32'h13,        32'd0};
      tbl[7]  = '{1'b1, 1'b0, 32'h0,          1'b1, BASE, 32'h13,        32'd0};
      tbl[8]  = '{1'b0, 1'b1, BASE + 32'd4,   1'b1, BASE, 32'h13,        32'd0};
      tbl[9]  = '{1'b0, 1'b0, 32'h0,          1'b0, BASE, 32'h13,        32'd1};
      tbl[10] = '{1'b0, 1'b1, BASE + 32'd8,   1'b1, BASE + 32'd4, 32'h0010_0093, 32'd1};

      rst = 1'b1;
      stall_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = 32'd0;
      imem_bus.imem_rvalid_i = 1'b0;
      imem_bus.imem_rdata_i  = 32'd0;
      mem_pend = 1'b0;
      mem_due  = 0;
      mem_data = 32'd0;
      cyc = 0;
      lat = 1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].st, 1'b0, 32'd0, 1'b0);
         chk($sformatf("tbl[%0d] imem_req_o", i), 32'(imem_bus.imem_req_o), 32'(tbl[i].ereq));
         if (tbl[i].ereq) chk($sformatf("tbl[%0d] imem_addr_o", i), imem_bus.imem_addr_o, tbl[i].eaddr);
         chk($sformatf("tbl[%0d] insn_valid_o", i), 32'(insn_valid_o), 32'(tbl[i].evalid));
         chk($sformatf("tbl[%0d] pc_o", i), pc_o, tbl[i].epc);
         chk($sformatf("tbl[%0d] insn_o", i), insn_o, tbl[i].einsn);
         chk($sformatf("tbl[%0d] fetch_count_o", i), fetch_count_o, tbl[i].ecnt);
         finish();
      end

      // Redirect while WAIT with 3-cycle memory: in-flight word dropped.
      lat = 3;
      reset_dut();
      step(1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      chk("redir_wait first req", 32'(imem_bus.imem_req_o), 32'd1);
      finish();
      step(1'b0, 1'b1, BASE + 32'h102);
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b0);
         chk("redir_wait drop valid", 32'(insn_valid_o), 32'd0);
         chk("redir_wait drop no req", 32'(imem_bus.imem_req_o), 32'd0);
         finish();
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      chk("redir_wait req", 32'(imem_bus.imem_req_o), 32'd1);
      chk("redir_wait addr", imem_bus.imem_addr_o, BASE + 32'h100);
      finish();
      expect_word("redir_wait", BASE + 32'h100);

      // Redirect coinciding with the response.
      lat = 1;
      reset_dut();
      step(1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b1, BASE + 32'h200, 1'b0);
      chk("redir_rv rvalid present", 32'(imem_bus.imem_rvalid_i), 32'd1);
      finish();
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      chk("redir_rv req", 32'(imem_bus.imem_req_o), 32'd1);
      chk("redir_rv addr", imem_bus.imem_addr_o, BASE + 32'h200);
      chk("redir_rv valid", 32'(insn_valid_o), 32'd0);
      finish();
      expect_word("redir_rv", BASE + 32'h200);

      // Reset mid-WAIT; the late response must be ignored.
      lat = 3;
      reset_dut();
      step(1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      finish();
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      chk("rst_wait valid", 32'(insn_valid_o), 32'd0);
      chk("rst_wait pc_o", pc_o, BASE);
      chk("rst_wait insn_o", insn_o, INSN_NOP);
      chk("rst_wait count", fetch_count_o, 32'd0);
      chk("rst_wait no req", 32'(imem_bus.imem_req_o), 32'd0);
      finish();
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      chk("rst_wait late rvalid", 32'(imem_bus.imem_rvalid_i), 32'd1);
      chk("rst_wait req", 32'(imem_bus.imem_req_o), 32'd1);
      chk("rst_wait addr", imem_bus.imem_addr_o, BASE);
      finish();
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      chk("rst_wait late ignored", 32'(insn_valid_o), 32'd0);
      finish();
      expect_word("rst_wait", BASE);

      // Counter wrap: hold a word under stall, preset the counter, accept once.
      lat = 1;
      reset_dut();
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'd0);
      force dut.fetch_count_o = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_count_o;
      m_cnt = 32'hFFFF_FFFF;
      step(1'b1, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      chk("wrap held valid", 32'(insn_valid_o), 32'd1);
      chk("wrap preset", fetch_count_o, 32'hFFFF_FFFF);
      finish();
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      chk("wrap count", fetch_count_o, 32'd0);
      finish();

      // Randomized traffic against the reference model.
      reset_dut();
      for (int n = 0; n < 600; n++) begin
         lat = int'($urandom_range(1, 4));
         step(($urandom % 10) < 3, ($urandom % 12) == 0,
              BASE + 32'($urandom_range(0, 1023)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
